// File: rtl/can_bus_ctrl.sv
// Intel-mode multiplexed AD bus master for up to 16 SJA1000-class CAN chips,
// with per-chip interrupt conditioning into a masked W1C pending register.
module can_bus_ctrl #(
  parameter int CH_NUM      = 2,
  parameter int ALE_CYC     = 2,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 2,
  parameter int RELEASE_CYC = 1024
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [31:0]       addr_32b_i,
  input  logic              wren_i,
  input  logic              rden_i,
  input  logic [31:0]       din_32b_i,
  output logic [31:0]       dout_32b_o,
  output logic              dout_32b_valid_o,
  output logic              busy_o,
  output logic              interrupt_o,
  input  logic [7:0]        can_ad_i,
  output logic [7:0]        can_ad_o,
  output logic              can_ad_oe,
  output logic [CH_NUM-1:0] can_cs_n,
  output logic              can_ale,
  output logic              can_wr_n,
  output logic              can_rd_n,
  input  logic [CH_NUM-1:0] can_int_n,
  output logic              can_rst_n
);

  localparam int CW = $clog2(RELEASE_CYC + 1);
  localparam logic [CW-1:0] REL_MAX  = CW'(RELEASE_CYC - 1);
  localparam logic [15:0]   ALE_LAST = 16'(ALE_CYC - 1);
  localparam logic [15:0]   STB_LAST = 16'(STROBE_CYC - 1);
  localparam logic [15:0]   HLD_LAST = 16'(HOLD_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AHOLD, S_STROBE, S_RECOVER} state_t;

  state_t      state, state_nxt;
  logic [15:0] phase, phase_nxt;
  logic        req_wr, req_wr_nxt;
  logic [3:0]  req_ch, req_ch_nxt;
  logic [7:0]  req_reg, req_reg_nxt, req_data, req_data_nxt;

  logic [31:0]       dout_nxt;
  logic              valid_nxt, busy_nxt, ale_nxt, wr_n_nxt, rd_n_nxt, oe_nxt;
  logic [7:0]        ad_nxt;
  logic [CH_NUM-1:0] cs_nxt;
  logic              active;

  logic              is_chip, is_ctrl, ch_ok, ctrl_wr;
  logic [31:0]       ctrl_rdata;

  logic [CH_NUM-1:0] sync1, sync2, armed, armed_nxt, pend, pend_nxt, mask, set_v, clr_v;
  logic              rstctl;
  logic [CW-1:0]     cnt [CH_NUM];
  logic [CW-1:0]     cnt_nxt [CH_NUM];

  logic unused_bits;
  assign unused_bits = ^{addr_32b_i[31:16], addr_32b_i[1:0], din_32b_i[31:8]};

  assign can_rst_n = ~rstctl;

  always_comb begin
    is_chip    = (addr_32b_i[15:12] == 4'h0);
    is_ctrl    = (addr_32b_i[15:12] == 4'h1);
    ch_ok      = ({1'b0, addr_32b_i[11:8]} < 5'(CH_NUM));
    ctrl_rdata = '0;
    case (addr_32b_i[3:2])
      2'd0:    ctrl_rdata[CH_NUM-1:0] = pend;
      2'd1:    ctrl_rdata[CH_NUM-1:0] = mask;
      2'd2:    ctrl_rdata[0] = rstctl;
      default: ctrl_rdata = '0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    req_wr_nxt   = req_wr;
    req_ch_nxt   = req_ch;
    req_reg_nxt  = req_reg;
    req_data_nxt = req_data;
    dout_nxt     = dout_32b_o;
    valid_nxt    = 1'b0;
    ctrl_wr      = 1'b0;
    case (state)
      S_IDLE: begin
        phase_nxt = '0;
        if (wren_i || rden_i) begin
          if (is_chip && ch_ok) begin
            state_nxt    = S_ADDR;
            req_wr_nxt   = wren_i;
            req_ch_nxt   = addr_32b_i[11:8];
            req_reg_nxt  = addr_32b_i[7:0];
            req_data_nxt = din_32b_i[7:0];
          end else if (wren_i) begin
            ctrl_wr = is_ctrl;
          end else begin
            valid_nxt = 1'b1;
            dout_nxt  = is_ctrl ? ctrl_rdata : '0;
          end
        end
      end
      S_ADDR: begin
        phase_nxt = phase + 16'd1;
        if (phase == ALE_LAST) begin
          state_nxt = S_AHOLD;
          phase_nxt = '0;
        end
      end
      S_AHOLD: begin
        state_nxt = S_STROBE;
        phase_nxt = '0;
      end
      S_STROBE: begin
        phase_nxt = phase + 16'd1;
        if (phase == STB_LAST) begin
          state_nxt = S_RECOVER;
          phase_nxt = '0;
          if (!req_wr) begin
            valid_nxt = 1'b1;
            dout_nxt  = {24'h0, can_ad_i};
          end
        end
      end
      S_RECOVER: begin
        phase_nxt = phase + 16'd1;
        if (phase == HLD_LAST) begin
          state_nxt = S_IDLE;
          phase_nxt = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Bus pins are decoded from the next state so they register in step with it.
    active   = (state_nxt != S_IDLE);
    busy_nxt = active;
    ale_nxt  = (state_nxt == S_ADDR);
    wr_n_nxt = !((state_nxt == S_STROBE) && req_wr_nxt);
    rd_n_nxt = !((state_nxt == S_STROBE) && !req_wr_nxt);
    oe_nxt   = 1'b0;
    ad_nxt   = '0;
    if (state_nxt == S_ADDR || state_nxt == S_AHOLD) begin
      oe_nxt = 1'b1;
      ad_nxt = req_reg_nxt;
    end else if ((state_nxt == S_STROBE || state_nxt == S_RECOVER) && req_wr_nxt) begin
      oe_nxt = 1'b1;
      ad_nxt = req_data_nxt;
    end
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      cs_nxt[i] = !(active && (req_ch_nxt == 4'(i)));
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      phase            <= '0;
      req_wr           <= 1'b0;
      req_ch           <= '0;
      req_reg          <= '0;
      req_data         <= '0;
      dout_32b_o       <= '0;
      dout_32b_valid_o <= 1'b0;
      busy_o           <= 1'b0;
      can_cs_n         <= '1;
      can_ale          <= 1'b0;
      can_wr_n         <= 1'b1;
      can_rd_n         <= 1'b1;
      can_ad_oe        <= 1'b0;
      can_ad_o         <= '0;
    end else begin
      state            <= state_nxt;
      phase            <= phase_nxt;
      req_wr           <= req_wr_nxt;
      req_ch           <= req_ch_nxt;
      req_reg          <= req_reg_nxt;
      req_data         <= req_data_nxt;
      dout_32b_o       <= dout_nxt;
      dout_32b_valid_o <= valid_nxt;
      busy_o           <= busy_nxt;
      can_cs_n         <= cs_nxt;
      can_ale          <= ale_nxt;
      can_wr_n         <= wr_n_nxt;
      can_rd_n         <= rd_n_nxt;
      can_ad_oe        <= oe_nxt;
      can_ad_o         <= ad_nxt;
    end
  end

  // A stuck-low line re-arms after the release timeout so it can pend again.
  always_comb begin
    set_v     = '0;
    armed_nxt = armed;
    cnt_nxt   = cnt;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (armed[i]) begin
        if (!sync2[i]) begin
          set_v[i]     = 1'b1;
          armed_nxt[i] = 1'b0;
          cnt_nxt[i]   = '0;
        end
      end else if (sync2[i] || cnt[i] == REL_MAX) begin
        armed_nxt[i] = 1'b1;
      end else begin
        cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
    clr_v    = (ctrl_wr && addr_32b_i[3:2] == 2'd0) ? din_32b_i[CH_NUM-1:0] : '0;
    pend_nxt = (pend & ~clr_v) | set_v;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync1       <= '1;
      sync2       <= '1;
      armed       <= '1;
      pend        <= '0;
      mask        <= '0;
      rstctl      <= 1'b1;
      interrupt_o <= 1'b0;
      cnt         <= '{default: '0};
    end else begin
      sync1       <= can_int_n;
      sync2       <= sync1;
      armed       <= armed_nxt;
      pend        <= pend_nxt;
      cnt         <= cnt_nxt;
      interrupt_o <= |(pend & mask);
      if (ctrl_wr && addr_32b_i[3:2] == 2'd1) mask <= din_32b_i[CH_NUM-1:0];
      if (ctrl_wr && addr_32b_i[3:2] == 2'd2) rstctl <= din_32b_i[0];
    end
  end

endmodule

// File: tb/tb_can_bus_ctrl.sv
// Randomized bench for can_bus_ctrl against a cycle-offset timing model
// and a register-level model of the control space.
module tb_can_bus_ctrl;
  localparam int CH   = 2;
  localparam int A    = 2;
  localparam int S    = 4;
  localparam int H    = 2;
  localparam int R    = 1024;
  localparam int LAST = A + S + H + 1;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   addr_32b_i = '0;
  logic          wren_i = 1'b0;
  logic          rden_i = 1'b0;
  logic [31:0]   din_32b_i = '0;
  logic [31:0]   dout_32b_o;
  logic          dout_32b_valid_o, busy_o, interrupt_o;
  logic [7:0]    can_ad_i = '0;
  logic [7:0]    can_ad_o;
  logic          can_ad_oe, can_ale, can_wr_n, can_rd_n, can_rst_n;
  logic [CH-1:0] can_cs_n;
  logic [CH-1:0] can_int_n = '1;

  can_bus_ctrl #(.CH_NUM(CH), .ALE_CYC(A), .STROBE_CYC(S), .HOLD_CYC(H), .RELEASE_CYC(R)) dut (
    .sys_clk(sys_clk), .rst(rst), .addr_32b_i(addr_32b_i), .wren_i(wren_i), .rden_i(rden_i),
    .din_32b_i(din_32b_i), .dout_32b_o(dout_32b_o), .dout_32b_valid_o(dout_32b_valid_o),
    .busy_o(busy_o), .interrupt_o(interrupt_o), .can_ad_i(can_ad_i), .can_ad_o(can_ad_o),
    .can_ad_oe(can_ad_oe), .can_cs_n(can_cs_n), .can_ale(can_ale), .can_wr_n(can_wr_n),
    .can_rd_n(can_rd_n), .can_int_n(can_int_n), .can_rst_n(can_rst_n)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  logic [CH-1:0] pend_m = '0;
  logic [CH-1:0] mask_m = '0;
  logic          rstctl_m = 1'b1;
  logic [31:0]   dout_m = '0;

  logic [7:0] bus_vec;
  assign bus_vec = {busy_o, can_ale, can_cs_n, can_wr_n, can_rd_n, can_ad_oe, can_rst_n};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] idle_vec();
    return {1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, ~rstctl_m};
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a[15:12] == 4'h1) begin
      case (a[3:2])
        2'd0: r[CH-1:0] = pend_m;
        2'd1: r[CH-1:0] = mask_m;
        2'd2: r[0] = rstctl_m;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // Request completing without a bus cycle; entered and left at a negedge.
  task automatic imm_txn(input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    exp_rd = model_rd(a);
    addr_32b_i = a; din_32b_i = d; wren_i = wr; rden_i = !wr;
    @(negedge sys_clk);
    wren_i = 1'b0; rden_i = 1'b0;
    if (wr && a[15:12] == 4'h1) begin
      case (a[3:2])
        2'd0: pend_m = pend_m & ~d[CH-1:0];
        2'd1: mask_m = d[CH-1:0];
        2'd2: rstctl_m = d[0];
        default: ;
      endcase
    end
    check("imm_bus", {24'h0, bus_vec}, {24'h0, idle_vec()});
    check("imm_valid", {31'h0, dout_32b_valid_o}, {31'h0, !wr});
    if (!wr) dout_m = exp_rd;
    check(wr ? "imm_hold" : "imm_rdata", dout_32b_o, dout_m);
  endtask

  // Full chip bus cycle, checked cycle by cycle against offsets from the request.
  task automatic chip_txn(input logic wr, input logic [3:0] ch, input logic [7:0] rg,
                          input logic [7:0] dat, input logic fixed_en, input logic [7:0] fixed_v,
                          input logic poke, input logic both);
    logic [7:0]    ad_hist [0:15];
    logic [7:0]    v, exp_vec, exp_ad;
    logic          e_busy, e_ale, e_stb, e_oe, e_valid;
    logic [CH-1:0] sel;
    sel = CH'(1 << ch);
    addr_32b_i = {16'($urandom), 4'h0, ch, rg};
    din_32b_i  = {24'($urandom), dat};
    wren_i = wr; rden_i = !wr || both;
    for (int k = 1; k <= LAST + 1; k++) begin
      @(negedge sys_clk);
      if (k == 1) begin wren_i = 1'b0; rden_i = 1'b0; end
      e_busy  = (k <= LAST);
      e_ale   = (k <= A);
      e_stb   = (k >= A + 2) && (k <= A + S + 1);
      e_oe    = (k <= A + 1) ? 1'b1 : (e_busy ? wr : 1'b0);
      e_valid = !wr && (k == A + S + 2);
      exp_ad  = (k <= A + 1) ? rg : dat;
      exp_vec = {e_busy, e_ale, e_busy ? ~sel : {CH{1'b1}}, !(e_stb && wr), !(e_stb && !wr),
                 e_oe, ~rstctl_m};
      check("bus", {24'h0, bus_vec}, {24'h0, exp_vec});
      if (e_oe) check("ad_o", {24'h0, can_ad_o}, {24'h0, exp_ad});
      check("valid", {31'h0, dout_32b_valid_o}, {31'h0, e_valid});
      if (e_valid) begin
        dout_m = {24'h0, ad_hist[A + S + 1]};
        check("rdata", dout_32b_o, dout_m);
      end
      if (k == LAST + 1) check("dout_hold", dout_32b_o, dout_m);
      v = fixed_en ? fixed_v : 8'($urandom);
      can_ad_i = v;
      ad_hist[k] = v;
      if (poke && k == 3) begin addr_32b_i = 32'h0000_1004; rden_i = 1'b1; end
      if (poke && k == 4) rden_i = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int unsigned c;
    logic [31:0] a, d;
    logic        w;
    int          rises, first_fall, exp_rises;
    int          rise_t [0:7];
    logic        prev;

    repeat (3) @(negedge sys_clk);
    check("rst_bus", {24'h0, bus_vec}, {24'h0, 8'b0_0_11_1_1_0_0});
    check("rst_dout", dout_32b_o, 32'h0);
    check("rst_valid", {31'h0, dout_32b_valid_o}, 32'h0);
    check("rst_irq", {31'h0, interrupt_o}, 32'h0);
    check("rst_ad_o", {24'h0, can_ad_o}, 32'h0);
    rst = 1'b0;
    @(negedge sys_clk);

    imm_txn(1'b1, 32'h0000_1008, 32'h0);
    chip_txn(1'b0, 4'd1, 8'h05, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0);
    check("plan_read", dout_32b_o, 32'h0000_00A5);
    chip_txn(1'b1, 4'd0, 8'h10, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0);
    chip_txn(1'b0, 4'd0, 8'h22, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    imm_txn(1'b0, 32'h0000_0505, 32'h0);

    for (int n = 0; n < 40; n++) begin
      c = $urandom_range(0, 5);
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      case (c)
        0, 1: chip_txn(c == 1, 4'($urandom_range(0, CH - 1)), 8'($urandom), 8'($urandom),
                       1'b0, 8'h00, 1'($urandom_range(0, 1)), (c == 1) && w);
        2: imm_txn(w, {16'($urandom), 4'h0, 4'($urandom_range(CH, 15)), 8'($urandom)}, d);
        3: imm_txn(1'b1, {16'($urandom), 4'h1, 8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom)}, d);
        4: imm_txn(1'b0, {16'($urandom), 4'h1, 8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom)}, d);
        default: imm_txn(w, {16'($urandom), 4'($urandom_range(2, 15)), 12'($urandom)}, d);
      endcase
    end

    // Stuck-low interrupt: each W1C clear exposes the next re-arm period.
    imm_txn(1'b1, 32'h0000_1004, 32'h3);
    imm_txn(1'b1, 32'h0000_1000, 32'h3);
    exp_rises = 0;
    for (int t = 4; t <= 3000; t += R + 1) exp_rises++;
    can_int_n[0] = 1'b0;
    rises = 0; first_fall = 0; prev = interrupt_o;
    for (int t = 1; t <= 3000; t++) begin
      @(negedge sys_clk);
      wren_i = 1'b0;
      if (interrupt_o && !prev) begin
        if (rises < 8) rise_t[rises] = t;
        rises++;
        addr_32b_i = 32'h0000_1000; din_32b_i = 32'h1; wren_i = 1'b1;
      end
      if (!interrupt_o && prev && first_fall == 0) first_fall = t;
      prev = interrupt_o;
    end
    wren_i = 1'b0;
    check("irq_rises", rises, exp_rises);
    for (int i = 0; i < 3; i++) check("irq_rise_time", rise_t[i], 4 + i * (R + 1));
    check("irq_fall_time", first_fall, rise_t[0] + 2);
    can_int_n[0] = 1'b1;
    repeat (4) @(negedge sys_clk);
    pend_m = '0;
    imm_txn(1'b0, 32'h0000_1000, 32'h0);
    @(negedge sys_clk);
    check("irq_clear", {31'h0, interrupt_o}, 32'h0);

    // Set on channel 1 lands on the same edge as its W1C clear.
    can_int_n[1] = 1'b0;
    repeat (2) @(negedge sys_clk);
    addr_32b_i = 32'h0000_1000; din_32b_i = 32'h2; wren_i = 1'b1;
    @(negedge sys_clk);
    wren_i = 1'b0;
    pend_m = 2'b10;
    imm_txn(1'b0, 32'h0000_1000, 32'h0);
    check("set_wins_irq", {31'h0, interrupt_o}, 32'h1);
    can_int_n[1] = 1'b1;
    repeat (3) @(negedge sys_clk);
    imm_txn(1'b1, 32'h0000_1000, 32'h3);
    imm_txn(1'b0, 32'h0000_1000, 32'h0);

    // Asynchronous reset in the middle of a read strobe.
    can_int_n[0] = 1'b0;
    repeat (5) @(negedge sys_clk);
    check("pre_rst_irq", {31'h0, interrupt_o}, 32'h1);
    addr_32b_i = 32'h0000_0033; rden_i = 1'b1;
    for (int k = 1; k <= A + 3; k++) begin
      @(negedge sys_clk);
      rden_i = 1'b0;
    end
    check("mid_strobe", {31'h0, can_rd_n}, 32'h0);
    can_int_n[0] = 1'b1;
    rst = 1'b1;
    #1;
    check("arst_bus", {24'h0, bus_vec}, {24'h0, 8'b0_0_11_1_1_0_0});
    check("arst_valid", {31'h0, dout_32b_valid_o}, 32'h0);
    check("arst_irq", {31'h0, interrupt_o}, 32'h0);
    check("arst_dout", dout_32b_o, 32'h0);
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    rstctl_m = 1'b1; mask_m = '0; pend_m = '0; dout_m = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      check("post_rst_idle", {23'h0, dout_32b_valid_o, bus_vec}, {23'h0, 1'b0, idle_vec()});
    end
    imm_txn(1'b0, 32'h0000_1000, 32'h0);
    imm_txn(1'b0, 32'h0000_1008, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
